fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of
//   control_unit and owns the PC.
// - Issues handshaked reads to instruction memory and presents ir_id; ir_id[31:26]
//   drives control_unit.ir.
// - Applies jump/branch redirects that the decode/execute logic returns to it.
// PARAMETERS
// RESET_PC  32'h0000_0000  PC loaded at reset
// NOP_INSTR 32'h0000_0000  Bubble inserted on flush (sll $0,$0,0 = rfmt opcode)
// PORTS
// clk            in   1   Rising-edge clock
// rst_n          in   1   Asynchronous active-low reset
// stall          in   1   Decode cannot accept; hold IF/ID contents
// branch_taken   in   1   Resolved branch is taken this cycle
// branch_target  in   32  Branch destination address
// jump           in   1   Jump from control_unit (j/jal) for the instruction in ID
// imem_rdata     in   32  Instruction word, valid when imem_ready=1
// imem_ready     in   1   Memory completes the current request this cycle
// imem_req       out  1   Read request
// imem_addr      out  32  Read address (= current PC)
// ir_id          out  32  IF/ID instruction
// pc_plus4_id    out  32  PC+4 of ir_id
// valid_id       out  1   ir_id holds a real instruction (0 = bubble)
// BEHAVIOUR
// Reset (async, rst_n=0)
// - pc=RESET_PC, imem_req=0, ir_id=NOP_INSTR, pc_plus4_id=0, valid_id=0, state=BOOT.
// Addressing and arithmetic
// - imem_addr=pc always. PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
// - Jump target = {pc_plus4_id[31:28], ir_id[25:0], 2'b00}.
// Redirect
// - redirect = jump | branch_taken. jump has priority over branch_taken.
// - Redirect overrides stall: ir_id<=NOP_INSTR, valid_id<=0, pc<=target.
// Memory handshake
// - While imem_req=1 and imem_ready=0, imem_addr stays stable. The only exception is
//   a redirect, which is recorded rather than applied to the address (see DISCARD).
// - A transfer happens on a cycle with imem_req=1 and imem_ready=1.
// - Zero-wait memory: imem_ready=1 every cycle gives one instruction per cycle.
// State machine
// - BOOT: imem_req=0 for one cycle, then -> FETCH.
// - FETCH: imem_req=1.
//   - Transfer and redirect: drop the word, pc<=target, stay in FETCH.
//   - Transfer, stall=0: ir_id<=imem_rdata, pc_plus4_id<=pc+4, valid_id<=1, pc<=pc+4.
//   - Transfer, stall=1: capture the word into the skid buffer (word plus its pc+4),
//     pc<=pc+4, -> HOLD.
//   - No transfer and redirect: save target in pending_pc -> DISCARD.
// - DISCARD: imem_req=1 at the old address. On imem_ready: drop the word,
//   pc<=pending_pc, -> FETCH. A newer redirect in DISCARD overwrites pending_pc.
// - HOLD: imem_req=0; IF/ID holds its contents.
//   - stall falls: IF/ID<=skid buffer, valid_id<=1, -> FETCH.
//   - Redirect in HOLD: clear the skid buffer, IF/ID<=bubble, pc<=target, -> FETCH.
// Stall outside a transfer cycle
// - With stall=1 and no redirect, ir_id, pc_plus4_id and valid_id hold. The stall
//   stops IF/ID updates only; it does not suppress fetch (see FETCH).
// Reset mid-operation
// - Abandons any outstanding request immediately.
// - The memory model must tolerate imem_req dropping without imem_ready.
// - There are no X outputs after reset.
// TESTING
// T1 Reset: release rst_n with ready=1 ->
//    - cycle 0: imem_req=0
//    - then imem_addr 0,4,8,...
//    - ir_id follows one cycle behind; valid_id=1 from the first capture.
// T2 Wait states: ready low 3 cycles on addr 0x10 -> addr held at 0x10 for 4 cycles;
//    ir_id updates once, pc_plus4_id=0x14.
// T3 Stall: stall=1 during fetch of 0x20 ->
//    - ir_id frozen; state HOLD, imem_req=0
//    - on stall release ir_id=word@0x20, then fetch 0x24.
// T4 Jump: ir_id=32'h0800_0040 (j), jump=1, pc_plus4_id=0x1000_0008 ->
//    next imem_addr=0x1000_0100, ir_id=NOP_INSTR, valid_id=0.
// T5 Redirect in flight: branch_taken=1, target 0x200 while ready=0 at 0x30 ->
//    - addr stays 0x30 until ready
//    - the 0x30 word is dropped; next addr=0x200
//    - no valid_id pulse for 0x30.
// T6 Reset mid-HOLD: assert rst_n=0 while in HOLD with stall=1 ->
//    - all outputs go to reset values asynchronously
//    - after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel between the fetch stage (master) and memory (slave).
// A read completes on a cycle with req=1 and ready=1; rdata is valid only then.
`timescale 1ns/1ps
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, addr, input rdata, ready);
  modport slave  (input req, addr, output rdata, ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, issues handshaked imem reads,
// buffers one word across a decode stall and applies jump/branch redirects.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  fetch_stage_if.master        imem,
  output logic [31:0]          ir_id,
  output logic [31:0]          pc_plus4_id,
  output logic                 valid_id
);

  typedef enum logic [1:0] {BOOT, FETCH, DISCARD, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] ir_n, pc4_n;
  logic        valid_n;
  logic [31:0] skid_ir, skid_ir_n, skid_pc4, skid_pc4_n;
  logic [31:0] pending_pc, pending_pc_n;
  logic        redirect, xfer;
  logic [31:0] target, pc_inc;

  assign redirect = jump | branch_taken;
  assign target   = jump ? {pc_plus4_id[31:28], ir_id[25:0], 2'b00} : branch_target;
  assign pc_inc   = pc + 32'd4;

  assign imem.req  = (state == FETCH) || (state == DISCARD);
  assign imem.addr = pc;
  assign xfer      = imem.req & imem.ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_n;
  end

  // NOTE: every signal written here is defaulted first, so no path can infer a latch.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ir_n         = ir_id;
    pc4_n        = pc_plus4_id;
    valid_n      = valid_id;
    skid_ir_n    = skid_ir;
    skid_pc4_n   = skid_pc4;
    pending_pc_n = pending_pc;

    case (state)
      BOOT: begin
        state_n = FETCH;
        if (redirect) pc_n = target;
      end
      FETCH: begin
        if (xfer) begin
          if (redirect) begin
            pc_n = target;
          end else if (stall) begin
            skid_ir_n  = imem.rdata;
            skid_pc4_n = pc_inc;
            pc_n       = pc_inc;
            state_n    = HOLD;
          end else begin
            ir_n    = imem.rdata;
            pc4_n   = pc_inc;
            valid_n = 1'b1;
            pc_n    = pc_inc;
          end
        end else if (redirect) begin
          // The address must stay stable until memory answers, so park the target.
          pending_pc_n = target;
          state_n      = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect) pending_pc_n = target;
        if (imem.ready) begin
          pc_n    = redirect ? target : pending_pc;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          skid_ir_n  = NOP_INSTR;
          skid_pc4_n = 32'd0;
          pc_n       = target;
          state_n    = FETCH;
        end else if (!stall) begin
          ir_n    = skid_ir;
          pc4_n   = skid_pc4;
          valid_n = 1'b1;
          state_n = FETCH;
        end
      end
      default: state_n = BOOT;
    endcase

    // A redirect squashes the instruction in ID even while decode is stalled.
    if (redirect) begin
      ir_n    = NOP_INSTR;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ir_id       <= NOP_INSTR;
      pc_plus4_id <= 32'd0;
      valid_id    <= 1'b0;
      skid_ir     <= NOP_INSTR;
      skid_pc4    <= 32'd0;
      pending_pc  <= RESET_PC;
    end else begin
      pc          <= pc_n;
      ir_id       <= ir_n;
      pc_plus4_id <= pc4_n;
      valid_id    <= valid_n;
      skid_ir     <= skid_ir_n;
      skid_pc4    <= skid_pc4_n;
      pending_pc  <= pending_pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based behavioural model of the fetch stage.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target;
  logic [31:0] ir_id, pc_plus4_id;
  logic        valid_id;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .imem          (bus),
    .ir_id         (ir_id),
    .pc_plus4_id   (pc_plus4_id),
    .valid_id      (valid_id)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address; one slot holds a j instruction.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0040;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign bus.rdata = mem_word(bus.addr);

  // Reference model: in-flight redirect and skid word are held as short queues.
  typedef struct {
    logic [31:0] w;
    logic [31:0] p4;
  } skid_t;

  logic [31:0] m_pc, m_ir, m_pc4;
  logic        m_valid;
  bit          m_boot;
  skid_t       skid_q[$];
  logic [31:0] pend_q[$];

  task automatic model_reset();
    m_pc = 32'h0; m_ir = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_boot = 1'b1;
    skid_q.delete();
    pend_q.delete();
  endtask

  task automatic model_step(input bit s, input bit br, input logic [31:0] bt,
                            input bit j, input bit rdy);
    bit          redir;
    logic [31:0] tgt;
    skid_t       e;
    redir = j || br;
    tgt   = j ? {m_pc4[31:28], m_ir[25:0], 2'b00} : bt;
    if (redir) begin
      m_ir = NOP; m_valid = 1'b0;
    end
    if (m_boot) begin
      m_boot = 1'b0;
      if (redir) m_pc = tgt;
    end else if (skid_q.size() != 0) begin
      if (redir) begin
        skid_q.delete();
        m_pc = tgt;
      end else if (!s) begin
        e = skid_q.pop_front();
        m_ir = e.w; m_pc4 = e.p4; m_valid = 1'b1;
      end
    end else if (rdy) begin
      if (pend_q.size() != 0) begin
        m_pc = redir ? tgt : pend_q[0];
        pend_q.delete();
      end else if (redir) begin
        m_pc = tgt;
      end else if (s) begin
        e.w = mem_word(m_pc); e.p4 = m_pc + 32'd4;
        skid_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end else begin
        m_ir = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (redir) begin
      pend_q.delete();
      pend_q.push_back(tgt);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ph);
    bit exp_req;
    exp_req = !m_boot && (skid_q.size() == 0);
    check({ph, " req"},   {31'd0, bus.req},  {31'd0, exp_req});
    check({ph, " addr"},  bus.addr,          m_pc);
    check({ph, " ir_id"}, ir_id,             m_ir);
    check({ph, " pc4"},   pc_plus4_id,       m_pc4);
    check({ph, " valid"}, {31'd0, valid_id}, {31'd0, m_valid});
  endtask

  // One clock: drive on the falling edge, compare just after, advance the model on the rising edge.
  task automatic cyc(input string ph, input bit s, input bit br, input logic [31:0] bt,
                     input bit j, input bit rdy);
    @(negedge clk);
    stall = s; branch_taken = br; branch_target = bt; jump = j; bus.ready = rdy;
    #1 compare_all(ph);
    @(posedge clk);
    model_step(s, br, bt, j, rdy);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; bus.ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // T1: boot cycle then sequential fetch 0,4,8,C
    for (int i = 0; i < 5; i++) cyc("t1", 0, 0, 0, 0, 1);
    #2 check("t1 addr", bus.addr, 32'h10);
    check("t1 ir", ir_id, mem_word(32'hC));

    // T2: three wait states at 0x10
    for (int i = 0; i < 3; i++) cyc("t2", 0, 0, 0, 0, 0);
    cyc("t2", 0, 0, 0, 0, 1);
    #2 check("t2 pc4", pc_plus4_id, 32'h14);
    check("t2 ir", ir_id, mem_word(32'h10));

    // T3: stall while fetching 0x20
    for (int i = 0; i < 3; i++) cyc("t3", 0, 0, 0, 0, 1);
    cyc("t3", 1, 0, 0, 0, 1);
    #2 check("t3 hold req", {31'd0, bus.req}, 32'd0);
    check("t3 frozen ir", ir_id, mem_word(32'h1C));
    cyc("t3", 1, 0, 0, 0, 1);
    cyc("t3", 0, 0, 0, 0, 1);
    #2 check("t3 release ir", ir_id, mem_word(32'h20));
    check("t3 next addr", bus.addr, 32'h24);

    // T4: branch to the j word, capture it, then jump
    cyc("t4", 0, 1, 32'h1000_0004, 0, 1);
    cyc("t4", 0, 0, 0, 0, 1);
    cyc("t4", 0, 0, 0, 1, 1);
    #2 check("t4 addr", bus.addr, 32'h1000_0100);
    check("t4 ir", ir_id, NOP);
    check("t4 valid", {31'd0, valid_id}, 32'd0);

    // T5: branch while a read of 0x30 is outstanding
    cyc("t5", 0, 1, 32'h30, 0, 1);
    cyc("t5", 0, 1, 32'h200, 0, 0);
    cyc("t5", 0, 0, 0, 0, 0);
    #2 check("t5 held addr", bus.addr, 32'h30);
    cyc("t5", 0, 0, 0, 0, 1);
    #2 check("t5 addr", bus.addr, 32'h200);
    check("t5 valid", {31'd0, valid_id}, 32'd0);

    // PC wrap at the top of the address space
    cyc("wrap", 0, 1, 32'hFFFF_FFFC, 0, 1);
    cyc("wrap", 0, 0, 0, 0, 1);
    #2 check("wrap pc4", pc_plus4_id, 32'h0);
    check("wrap addr", bus.addr, 32'h0);

    // Redirect while holding a skid word
    cyc("hred", 1, 0, 0, 0, 1);
    cyc("hred", 1, 1, 32'h400, 0, 0);
    #2 check("hred addr", bus.addr, 32'h400);
    check("hred req", {31'd0, bus.req}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
          $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6));

    // T6: asynchronous reset while in HOLD
    for (int i = 0; i < 3; i++) cyc("t6", 1, 0, 0, 0, 1);
    #2 check("t6 in hold", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6 rst req", {31'd0, bus.req}, 32'd0);
    check("t6 rst addr", bus.addr, 32'h0);
    check("t6 rst ir", ir_id, NOP);
    check("t6 rst pc4", pc_plus4_id, 32'h0);
    check("t6 rst valid", {31'd0, valid_id}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t6 restart", 0, 0, 0, 0, 1);
    #2 check("t6 restart addr", bus.addr, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
